// File: rtl/bn_requant_stage.sv
// Batchnorm bias add, round-half-up rescale, saturation and optional ReLU.
// Two-stage valid/ready pipeline with a channel sequencer and a saturation event counter.
module bn_requant_stage #(
  parameter int                  BITS  = 17,
  parameter int                  NFRAC = 8,
  parameter int                  NCH   = 16,
  parameter logic [NCH*BITS-1:0] BIAS  = '0,
  parameter int                  RELU  = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [2*BITS-1:0]               in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [BITS-1:0]                 out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic                                   out_last,
  output logic [15:0]                            sat_count
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW  = 2*BITS + 1;
  localparam int RW  = SW + 1;

  localparam logic signed [RW-1:0] MAXV = {{(RW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
  localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (NFRAC-1);

  logic                   s1_valid_q, s1_valid_d;
  logic signed [SW-1:0]   s1_sum_q, s1_sum_d;
  logic [CHW-1:0]         s1_ch_q, s1_ch_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [BITS-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]         out_ch_q, out_ch_d;
  logic                   out_last_q, out_last_d;
  logic                   sat_q, sat_d;
  logic [15:0]            sat_count_q, sat_count_d;

  logic                   s2_adv, s1_adv, in_xfer, out_xfer;
  logic signed [BITS-1:0] bias_sel;
  logic signed [SW-1:0]   bias_ext, in_ext, sum_new;
  logic signed [RW-1:0]   sum_ext, rnd;
  logic signed [BITS-1:0] val;
  logic                   val_sat;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_xfer  = in_valid && s1_adv;
  assign out_xfer = out_valid_q && out_ready;

  // Stage-1 arithmetic: bias aligned to the product's fractional point, one guard bit.
  always_comb begin
    bias_sel = BIAS[int'(ch_q)*BITS +: BITS];
    bias_ext = {{(SW-BITS){bias_sel[BITS-1]}}, bias_sel} <<< NFRAC;
    in_ext   = {in_data[2*BITS-1], in_data};
    sum_new  = in_ext + bias_ext;
  end

  // Stage-2 arithmetic: round half up, saturate, then the ReLU clamp (never counted as saturation).
  always_comb begin
    sum_ext = {s1_sum_q[SW-1], s1_sum_q};
    rnd     = (sum_ext + HALF) >>> NFRAC;
    if (rnd > MAXV) begin
      val     = MAXV[BITS-1:0];
      val_sat = 1'b1;
    end else if (rnd < MINV) begin
      val     = MINV[BITS-1:0];
      val_sat = 1'b1;
    end else begin
      val     = rnd[BITS-1:0];
      val_sat = 1'b0;
    end
    if (RELU != 0 && val[BITS-1]) begin
      val = '0;
    end else begin
      val = val;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_ch_d     = s1_ch_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    sat_count_d = sat_count_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_xfer) begin
      s1_sum_d = sum_new;
      s1_ch_d  = ch_q;
      ch_d     = (ch_q == CHW'(NCH-1)) ? '0 : ch_q + 1'b1;
    end else begin
      ch_d = ch_q;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = val;
        out_ch_d   = s1_ch_q;
        out_last_d = (s1_ch_q == CHW'(NCH-1));
        sat_d      = val_sat;
      end else begin
        sat_d = sat_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (out_xfer && sat_q && sat_count_q != 16'hFFFF) begin
      sat_count_d = sat_count_q + 16'd1;
    end else begin
      sat_count_d = sat_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      sat_count_q <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_ch_q     <= s1_ch_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_bn_requant_stage.sv
// Scoreboard bench for bn_requant_stage: NCH=4, biases {+1,-2,0,0}, plus a RELU=1 instance.
module tb_bn_requant_stage;

  localparam logic [67:0] TB_BIAS = {17'h00000, 17'h00000, 17'h1FFFE, 17'h00001};

  typedef struct {
    logic signed [16:0] data;
    logic [1:0]         ch;
    logic               last;
  } item_t;

  logic               clk;
  logic               reset, in_valid, out_ready;
  logic               in_ready, out_valid, out_last;
  logic signed [33:0] in_data;
  logic signed [16:0] out_data;
  logic [1:0]         out_ch;
  logic [15:0]        sat_count;

  logic               r_reset, r_in_valid, r_out_ready;
  logic               r_in_ready, r_out_valid, r_out_last;
  logic signed [33:0] r_in_data;
  logic signed [16:0] r_out_data;
  logic [1:0]         r_out_ch;
  logic [15:0]        r_sat_count;

  int    checks = 0;
  int    errors = 0;
  int    accepted = 0;
  logic [1:0] tb_ch = 2'd0;
  item_t sb[$];

  bn_requant_stage #(.BITS(17), .NFRAC(8), .NCH(4), .BIAS(TB_BIAS), .RELU(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .sat_count(sat_count)
  );

  bn_requant_stage #(.BITS(17), .NFRAC(8), .NCH(4), .BIAS(TB_BIAS), .RELU(1)) dut_relu (
    .clk(clk), .reset(r_reset), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .out_ch(r_out_ch),
    .out_last(r_out_last), .sat_count(r_sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: the beat visible at a negedge with ready high transfers on the next posedge.
  always @(negedge clk) begin
    item_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got beat data=%0d ch=%0d, expected no beat", out_data, out_ch);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_ch !== e.ch || out_last !== e.last) begin
          errors++;
          $display("FAIL sb_beat: got data=%0d ch=%0d last=%0b, expected data=%0d ch=%0d last=%0b",
                   out_data, out_ch, out_last, e.data, e.ch, e.last);
        end
      end
    end
  end

  task automatic send(input logic signed [33:0] d, input logic signed [16:0] exp_d);
    item_t it;
    bit    ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: got in_ready=0 for 50 cycles, expected acceptance of %0d", d);
    end else begin
      it.data = exp_d;
      it.ch   = tb_ch;
      it.last = (tb_ch == 2'd3);
      sb.push_back(it);
      tb_ch = tb_ch + 2'd1;
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; r_reset = 1'b1;
    in_valid = 1'b0; r_in_valid = 1'b0;
    in_data = '0; r_in_data = '0;
    out_ready = 1'b1; r_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 17'sd0 || out_ch !== 2'd0 || out_last !== 1'b0 ||
        sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b d=%0d ch=%0d last=%0b sat=%0d, expected all 0",
               out_valid, out_data, out_ch, out_last, sat_count);
    end
    reset = 1'b0; r_reset = 1'b0;
    tb_ch = 2'd0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%0b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    send(34'sd768, 17'sd4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid=%0b one cycle after transfer, expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 17'sd4 || out_ch !== 2'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL latency_beat: got v=%0b d=%0d ch=%0d last=%0b, expected v=1 d=4 ch=0 last=0",
               out_valid, out_data, out_ch, out_last);
    end
    drain();
  endtask

  task automatic test_rounding();
    send(34'sd0, -17'sd2);
    send(34'sd384, 17'sd2);
    send(-34'sd384, -17'sd1);
    send(34'sd0, 17'sd1);
    send(34'sd0, -17'sd2);
    send(34'sd383, 17'sd1);
    drain();
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL round_sat: got sat_count=%0d, expected 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    send(34'sd1073741824, 17'sd65535);
    send(-34'sd1073741824, -17'sd65536);
    drain();
    checks++;
    if (sat_count !== 16'd2) begin
      errors++;
      $display("FAIL sat_count2: got sat_count=%0d, expected 2", sat_count);
    end
    send(34'sd0, -17'sd2);
    send(34'sd16776960, 17'sd65535);
    send(34'sd0, 17'sd0);
    drain();
    checks++;
    if (sat_count !== 16'd2) begin
      errors++;
      $display("FAIL sat_exact_fit: got sat_count=%0d, expected 2", sat_count);
    end
  endtask

  task automatic test_backpressure();
    int acc0;
    acc0 = accepted;
    out_ready = 1'b0;
    fork
      begin
        send(34'sd2560, 17'sd11);
        send(34'sd5120, 17'sd18);
        send(34'sd7680, 17'sd30);
        send(34'sd10240, 17'sd40);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 17'sd11 || out_ch !== 2'd0) begin
              errors++;
              $display("FAIL bp_hold: got v=%0b d=%0d ch=%0d, expected v=1 d=11 ch=0",
                       out_valid, out_data, out_ch);
            end
          end
        end
        checks++;
        if (accepted - acc0 != 2 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_occupancy: got accepted=%0d in_ready=%0b, expected 2 and 0",
                   accepted - acc0, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midstream();
    send(34'sd0, 17'sd1);
    send(34'sd0, -17'sd2);
    reset = 1'b1;
    sb.delete();
    tb_ch = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset: got out_valid=%0b sat_count=%0d, expected 0 and 0", out_valid, sat_count);
    end
    send(34'sd768, 17'sd4);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      errors++;
      $display("FAIL midreset_ch: got out_valid=%0b out_ch=%0d, expected 1 and 0", out_valid, out_ch);
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got out_valid=%0b after draining, expected 0", out_valid);
    end
  endtask

  task automatic relu_beat(input logic signed [33:0] d, input logic signed [16:0] exp_d,
                           input logic [1:0] exp_ch, input logic [15:0] exp_sat);
    bit found;
    found = 1'b0;
    checks++;
    if (r_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL relu_ready: got in_ready=%0b, expected 1", r_in_ready);
    end
    r_in_valid = 1'b1;
    r_in_data  = d;
    @(posedge clk); #1;
    r_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (r_out_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || r_out_data !== exp_d || r_out_ch !== exp_ch || r_out_last !== (exp_ch == 2'd3)) begin
      errors++;
      $display("FAIL relu_beat: got v=%0b d=%0d ch=%0d last=%0b, expected v=1 d=%0d ch=%0d",
               found, r_out_data, r_out_ch, r_out_last, exp_d, exp_ch);
    end
    @(posedge clk); #1;
    checks++;
    if (r_sat_count !== exp_sat) begin
      errors++;
      $display("FAIL relu_sat: got sat_count=%0d, expected %0d", r_sat_count, exp_sat);
    end
  endtask

  task automatic test_relu();
    relu_beat(-34'sd1073741824, 17'sd0, 2'd0, 16'd1);
    relu_beat(34'sd0, 17'sd0, 2'd1, 16'd1);
    relu_beat(-34'sd128, 17'sd0, 2'd2, 16'd1);
    relu_beat(34'sd512, 17'sd2, 2'd3, 16'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    test_relu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
